// File: rtl/pll_clk_supervisor.sv
// -----------------------------------------------------------------------------
// pll_clk_supervisor
//
// Purpose:
//   Supervises an external PLL primitive and generates per-channel fractional
//   clock enables.
//   - Holds the PLL in reset for a fixed number of cycles on each attempt.
//   - Waits for lock and qualifies it with a run of consecutive locked cycles.
//   - Retries on a lock timeout or on lock loss, and parks in FAULT after
//     MAX_RETRY failed attempts.
//   - While running, NUM_CH phase accumulators produce one-cycle clock-enable
//     pulses at an average rate of f_clkin * inc / 2^ACC_W.
//
// Optional feature (compile-time macro):
//   PLL_CLK_SUPERVISOR_STATS_EN
//     Defined   : lock_loss is a saturating count of lock losses seen while in
//                 RUN. Only resetn clears it; clear does not.
//     Undefined : no counter is built and lock_loss reads 16'h0000.
//
// Ports:
//   clkin      in   board clock, all logic on its rising edge
//   resetn     in   asynchronous active-low reset
//   pll_lock   in   PLL lock, asynchronous to clkin (2-FF synchronised)
//   pll_reset  out  PLL primitive reset, active high (PRST and FAULT)
//   sys_rst_n  out  downstream reset, released only in RUN
//   ready      out  high only in RUN
//   fault      out  high only in FAULT
//   retry_cnt  out  failed attempts since resetn or clear
//   clear      in   one-cycle pulse: zero retry_cnt and restart from PRST
//   inc_wr     in   phase increment write strobe
//   inc_ch     in   channel index for the write; out-of-range is ignored
//   inc_data   in   phase increment value
//   ce         out  per-channel clock-enable pulses
//   lock_loss  out  lock-loss statistics (see macro above)
// -----------------------------------------------------------------------------
module pll_clk_supervisor #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_CYC    = 1024,
  parameter int TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY   = 4,
  localparam int RC_W       = $clog2(MAX_RETRY + 1),
  localparam int CH_W       = $clog2(NUM_CH) + 1
) (
  input  logic              clkin,
  input  logic              resetn,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              fault,
  output logic [RC_W-1:0]   retry_cnt,
  input  logic              clear,
  input  logic              inc_wr,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [ACC_W-1:0]  inc_data,
  output logic [NUM_CH-1:0] ce,
  output logic [15:0]       lock_loss
);

  // State encoding kept as plain constants for compatibility with the
  // legacy wrapper's debug taps.
  localparam logic [2:0] S_PRST   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  // One shared counter serves PRST, WAIT_LOCK and STABLE. Its width covers
  // the longest of the three intervals.
  localparam int CNT_MAX_A = (PLL_RST_CYC > LOCK_CYC) ? PLL_RST_CYC : LOCK_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
  localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [RC_W-1:0]  RETRY_LIM = RC_W'(MAX_RETRY);

  // Accumulator add that returns the carry-out in the top bit.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic lock_meta_q, lock_meta_d;
  logic lock_s_q,    lock_s_d;

  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Supervisor FSM
  // ---------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [RC_W-1:0] retry_q, retry_d;
  logic            fail;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      S_PRST: begin
        if (cnt_q == PRST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A lock glitch while qualifying is not a failure. It restarts the
        // timeout window from zero.
        if (!lock_s_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s_q) fail = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PRST;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
      retry_d = retry_q + RC_W'(1);
      cnt_d   = '0;
      state_d = (retry_d == RETRY_LIM) ? S_FAULT : S_PRST;
    end

    // clear has priority over everything, including a same-cycle failure,
    // and is never counted as an attempt.
    if (clear) begin
      state_d = S_PRST;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_PRST;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // All status outputs decode the registered state only.
  logic run;
  assign run       = (state_q == S_RUN);
  assign ready     = run;
  assign sys_rst_n = run;
  assign fault     = (state_q == S_FAULT);
  assign pll_reset = (state_q == S_PRST) || (state_q == S_FAULT);
  assign retry_cnt = retry_q;

  // ---------------------------------------------------------------------------
  // Phase accumulators and increments
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [ACC_W:0]    sum;

  always_comb begin
    sum  = '0;
    ce_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = '0;
      inc_d[c] = inc_q[c];
      // Outside RUN the accumulators are held at zero, so all channels start
      // phase-aligned on RUN entry.
      if (run) begin
        sum      = acc_add(acc_q[c], inc_q[c]);
        acc_d[c] = sum[ACC_W-1:0];
        ce_d[c]  = sum[ACC_W];
      end
      // Matching by equality means an out-of-range index writes nothing.
      if (inc_wr && (inc_ch == CH_W'(c))) inc_d[c] = inc_data;
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        inc_q[c] <= '0;
      end
      ce_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        inc_q[c] <= inc_d[c];
      end
      ce_q <= ce_d;
    end
  end

  // The last carry registered in RUN must not leak out once the state has
  // left RUN.
  assign ce = ce_q & {NUM_CH{run}};

  // ---------------------------------------------------------------------------
  // Lock-loss statistics
  // ---------------------------------------------------------------------------
`ifdef PLL_CLK_SUPERVISOR_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    // A loss that coincides with clear is overridden by clear and is not
    // counted.
    if (run && !lock_s_q && !clear) loss_d = sat_inc16(loss_q);
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) loss_q <= '0;
    else         loss_q <= loss_d;
  end

  assign lock_loss = loss_q;
`else
  assign lock_loss = 16'h0000;
`endif

endmodule
